// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants (datapath width, PC-select encodings, reset PC, NOP).
package fetch_stage_pkg;
    localparam int          XLEN        = 32;
    localparam logic [1:0]  PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0]  PC_SEL_BR   = 2'b01;
    localparam logic [1:0]  PC_SEL_JALR = 2'b10;
    localparam logic [31:0] RESET_PC    = 32'h0000_2000;
    localparam logic [31:0] NOP         = 32'd0;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selector with word alignment of redirect targets.
//   pc, pc_sel, br_target, jalr_target, advance -> redirect, next_pc, pc_plus_4
module fetch_next_pc #(
    parameter int XLEN = fetch_stage_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            advance,
    output logic            redirect,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus_4
);
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] target;

    always_comb begin
        redirect    = pc_sel == PC_SEL_BR || pc_sel == PC_SEL_JALR;
        target      = pc_sel == PC_SEL_JALR ? jalr_target : br_target;
        target[1:0] = 2'b00;
        pc_plus_4   = pc + XLEN'(4);
        next_pc     = redirect ? target : advance ? pc_plus_4 : pc;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage; owns the fetch PC, keeps one imem request outstanding, buffers under stall,
// applies execute redirects and drops wrong-path responses.
//   in : clk, rst (async, active-low), stallF, pc_sel, br_target, jalr_target,
//        imem_req_ready, imem_resp_valid, imem_resp_data
//   out: imem_req_valid, imem_req_addr, pcF, pc_plus_4F, instrF, instr_validF
module fetch_stage #(
    parameter int              XLEN     = fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pc_plus_4F,
    output logic [31:0]     instrF,
    output logic            instr_validF
);
    import fetch_stage_pkg::*;

    typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_HOLD} fs_state_e;

    fs_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     buf_q, buf_d;
    logic            redirect, deliver, advance;

    fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc          (pc_q),
        .pc_sel      (pc_sel),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .advance     (advance),
        .redirect    (redirect),
        .next_pc     (pc_d),
        .pc_plus_4   (pc_plus_4F)
    );

    always_comb begin
        // A redirect kills whatever would be presented this cycle.
        deliver        = !redirect && ((state_q == FS_WAIT && imem_resp_valid && !drop_q) || state_q == FS_HOLD);
        advance        = deliver && !stallF;
        instr_validF   = deliver;
        instrF         = !deliver ? NOP : state_q == FS_HOLD ? buf_q : imem_resp_data;
        imem_req_valid = rst && state_q == FS_REQ;
        imem_req_addr  = pc_q;
        pcF            = pc_q;
        state_d        = state_q;
        drop_d         = drop_q;
        buf_d          = buf_q;
        case (state_q)
            FS_REQ: begin
                // A request accepted alongside a redirect is already wrong-path.
                if (imem_req_ready) begin
                    state_d = FS_WAIT;
                    drop_d  = redirect;
                end
            end
            FS_WAIT: begin
                if (imem_resp_valid) begin
                    drop_d  = 1'b0;
                    buf_d   = imem_resp_data;
                    state_d = (!drop_q && !redirect && stallF) ? FS_HOLD : FS_REQ;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            FS_HOLD: state_d = (redirect || !stallF) ? FS_REQ : FS_HOLD;
            default: state_d = FS_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FS_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            buf_q   <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized bench for fetch_stage against an address-keyed memory and PC model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallF = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] br_target = '0, jalr_target = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic [31:0] pcF, pc_plus_4F, instrF;
    logic        instr_validF;

    int tests = 0, fails = 0, delivered = 0;
    logic        rdy = 1'b1;
    int          lat = 0;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0, exp_pc = 32'h2000, prev_addr = '0;
    logic        prev_hold = 1'b0, prev_stuck = 1'b0;
    logic        o_valid, o_req_valid;
    logic [31:0] o_instr, o_pc, o_pc4, o_addr;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stallF(stallF), .pc_sel(pc_sel),
        .br_target(br_target), .jalr_target(jalr_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .pcF(pcF), .pc_plus_4F(pc_plus_4F), .instrF(instrF), .instr_validF(instr_validF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h2000 ? 32'h0050_0093 : (a ^ 32'hA5A5_0000) * 32'h0001_0003 + 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_valid", instr_validF, 0);
        chk("rst_instr", instrF, 0);
        chk("rst_pc", pcF, 32'h2000);
        pending = 1'b0; prev_hold = 1'b0; prev_stuck = 1'b0; exp_pc = 32'h2000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: called just after a negedge; memory responds, outputs are checked, model advances.
    task automatic cyc();
        logic rv, redir;
        rv = pending && cnt == 0;
        imem_resp_valid = rv;
        imem_resp_data  = rv ? mem(pend_addr) : 32'hDEAD_BEEF;
        imem_req_ready  = rdy;
        #2;
        redir = pc_sel == 2'b01 || pc_sel == 2'b10;
        chk("pc_plus_4", pc_plus_4F, pcF + 32'd4);
        chk("pcF", pcF, exp_pc);
        chk("instr", instrF, instr_validF ? mem(pcF) : 32'd0);
        if (redir) chk("redirect_kills_valid", instr_validF, 0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, pcF);
        chk("one_outstanding", imem_req_valid && pending, 0);
        if (prev_hold && !redir) chk("hold_valid", instr_validF, 1);
        if (prev_stuck) begin
            chk("req_keep", imem_req_valid, 1);
            chk("addr_keep", imem_req_addr, prev_addr);
        end
        o_valid = instr_validF; o_instr = instrF; o_pc = pcF; o_pc4 = pc_plus_4F;
        o_req_valid = imem_req_valid; o_addr = imem_req_addr;
        if (instr_validF && !stallF) delivered++;
        prev_hold  = instr_validF && stallF && !redir;
        prev_stuck = imem_req_valid && !rdy && !redir;
        prev_addr  = imem_req_addr;
        exp_pc = redir ? ((pc_sel == 2'b10 ? jalr_target : br_target) & ~32'd3)
               : (instr_validF && !stallF) ? exp_pc + 32'd4 : exp_pc;
        if (rv) pending = 1'b0;
        else if (pending) cnt--;
        if (imem_req_valid && rdy) begin
            pending = 1'b1; cnt = lat; pend_addr = imem_req_addr;
        end
        @(negedge clk);
    endtask

    initial begin
        int d0;
        @(negedge clk);
        do_reset();
        // Sequential fetch, 1-cycle memory
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("seq_req", o_req_valid, 1);
            chk("seq_addr", o_addr, 32'h2000 + 4 * i);
            chk("seq_no_valid", o_valid, 0);
            cyc();
            chk("seq_valid", o_valid, 1);
            chk("seq_pc", o_pc, 32'h2000 + 4 * i);
        end
        // Stall while response arrives
        do_reset();
        stallF = 1'b1;
        cyc();
        chk("stall_req_addr", o_addr, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_valid", o_valid, 1);
            chk("stall_instr", o_instr, 32'h0050_0093);
            chk("stall_pc", o_pc, 32'h2000);
            chk("stall_no_req", o_req_valid, 0);
        end
        stallF = 1'b0;
        cyc();
        chk("unstall_valid", o_valid, 1);
        lat = 2;
        cyc();
        chk("unstall_req", o_req_valid, 1);
        chk("unstall_addr", o_addr, 32'h2004);
        // Branch redirect while waiting
        lat = 0;
        pc_sel = 2'b01; br_target = 32'h2040;
        cyc();
        chk("br_valid0", o_valid, 0);
        pc_sel = 2'b00;
        cyc();
        chk("br_valid1", o_valid, 0);
        cyc();
        chk("br_dropped", o_valid, 0);
        cyc();
        chk("br_req", o_req_valid, 1);
        chk("br_addr", o_addr, 32'h2040);
        cyc();
        chk("br_deliver", o_valid, 1);
        chk("br_instr", o_instr, mem(32'h2040));
        // JALR during HOLD
        stallF = 1'b1;
        cyc();
        chk("jalr_pre_addr", o_addr, 32'h2044);
        cyc();
        chk("jalr_pre_valid", o_valid, 1);
        cyc();
        chk("jalr_hold_valid", o_valid, 1);
        pc_sel = 2'b10; jalr_target = 32'h2103;
        cyc();
        chk("jalr_valid", o_valid, 0);
        pc_sel = 2'b00; stallF = 1'b0;
        // Ready low for 4 cycles
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("nordy_req", o_req_valid, 1);
            chk("nordy_addr", o_addr, 32'h2100);
            chk("nordy_pc", o_pc, 32'h2100);
        end
        // Async reset mid-WAIT
        rdy = 1'b1; lat = 3;
        cyc();
        cyc();
        chk("wait_no_req", o_req_valid, 0);
        do_reset();
        lat = 0;
        cyc();
        chk("post_rst_req", o_req_valid, 1);
        chk("post_rst_addr", o_addr, 32'h2000);
        // PC wrap via aligned redirect
        pc_sel = 2'b01; br_target = 32'hFFFF_FFFE;
        cyc();
        pc_sel = 2'b00; rdy = 1'b0;
        cyc();
        chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", o_pc4, 32'h0);
        // Randomized traffic
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 19);
            stallF      = $urandom_range(0, 9) < 3;
            pc_sel      = r == 0 ? 2'b01 : r == 1 ? 2'b10 : r == 2 ? 2'b11 : 2'b00;
            br_target   = 32'h4000 + $urandom_range(0, 1023);
            jalr_target = 32'h6000 + $urandom_range(0, 1023);
            rdy         = $urandom_range(0, 9) < 7;
            lat         = $urandom_range(0, 3);
            cyc();
        end
        chk("progress", (delivered - d0) >= 200, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
